// File: rtl/axi_lite_rd_slave.sv
// AXI4-Lite read-channel slave with a local bank of 32-bit registers.
// Each AR handshake is decoded against BASE_ADDR. The R beat is returned after
// RD_LATENCY wait states. Local logic loads the bank through a write port.
// Optional macro AXI_LITE_RD_SLAVE_ALIGN_CHECK_EN: when defined, unaligned
// addresses answer SLVERR with rdata=0.
module axi_lite_rd_slave #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000,
   parameter int                NUM_REGS   = 8,
   parameter int                RD_LATENCY = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        arvalid,
   output logic                        arready,
   input  logic [ADDR_W-1:0]           araddr,
   output logic                        rvalid,
   input  logic                        rready,
   output logic [31:0]                 rdata,
   output logic [1:0]                  rresp,
   input  logic                        reg_we,
   input  logic [$clog2(NUM_REGS)-1:0] reg_waddr,
   input  logic [31:0]                 reg_wdata,
   output logic                        busy
);

   localparam int                IDX_W     = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * NUM_REGS);
   localparam logic [3:0]        WAIT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic              capture;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_data;
   logic [1:0]        cap_resp;
   logic [31:0]       regs [NUM_REGS];

   // The address falls inside the register window (and is aligned when checked).
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      logic              ok;
      off = a - BASE_ADDR;
      ok  = (a >= BASE_ADDR) && (off < SPAN);
`ifdef AXI_LITE_RD_SLAVE_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
`endif
      return ok;
   endfunction

   // Register index selected by a byte address inside the window.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   // With zero wait states the capture happens on the handshake edge itself.
   // The capture therefore uses the live address while still in IDLE.
   always_comb begin
      cap_addr = (state == IDLE) ? araddr : addr_q;
      if (addr_ok(cap_addr)) begin
         cap_data = regs[addr_idx(cap_addr)];
         cap_resp = RESP_OKAY;
      end else begin
         cap_data = 32'h0000_0000;
         cap_resp = RESP_SLVERR;
      end
   end

   // Next-state logic: address latch, wait counter and capture strobe.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = addr_q;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (arvalid && arready) begin
               addr_n = araddr;
               if (RD_LATENCY == 0) begin
                  state_n = RESP;
                  capture = 1'b1;
               end else begin
                  state_n = WAIT;
                  cnt_n   = WAIT_LOAD;
               end
            end else begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_n = RESP;
               capture = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP: begin
            if (rready) begin
               state_n = IDLE;
            end else begin
               state_n = RESP;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register and registered AXI outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         busy    <= 1'b0;
         rdata   <= 32'h0000_0000;
         rresp   <= 2'b00;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         addr_q  <= addr_n;
         arready <= (state_n == IDLE);
         rvalid  <= (state_n == RESP);
         busy    <= (state_n != IDLE);
         if (capture) begin
            rdata <= cap_data;
            rresp <= cap_resp;
         end
      end
   end

   // Local register bank; a write on the capture edge is not seen by that read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= 32'h0000_0000;
         end
      end else if (reg_we) begin
         regs[reg_waddr] <= reg_wdata;
      end
   end

endmodule

// File: tb/tb_axi_lite_rd_slave.sv
// Self-checking bench for axi_lite_rd_slave: directed scenarios plus a
// randomized read/write mix, checked against a register-array reference model.
module tb_axi_lite_rd_slave;

   localparam int          ADDR_W     = 32;
   localparam logic [31:0] BASE       = 32'h4000_0000;
   localparam int          NUM_REGS   = 8;
   localparam int          RD_LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        reg_we;
   logic [2:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mregs [NUM_REGS];

   axi_lite_rd_slave #(
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_REGS(NUM_REGS), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: window check, word index and optional alignment rule.
   function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                      output logic [1:0] r);
      longint unsigned ua, lo, hi;
      ua = a; lo = BASE; hi = lo + 4 * NUM_REGS;
      d = 32'h0; r = 2'b10;
      if (ua >= lo && ua < hi) begin
`ifdef AXI_LITE_RD_SLAVE_ALIGN_CHECK_EN
         if (ua % 4 != 0) return;
`endif
         d = mregs[int'((ua - lo) / 4)];
         r = 2'b00;
      end
   endfunction

   task automatic reg_write(input int idx, input logic [31:0] d);
      reg_we = 1'b1; reg_waddr = 3'(idx); reg_wdata = d;
      @(posedge clk); #1;
      reg_we = 1'b0;
      mregs[idx] = d;
   endtask

   // One full read; wr_at>=0 lands a local write on edge T+wr_at (T = AR edge).
   task automatic do_read(input logic [31:0] a, input int hold, input int wr_at,
                          input int wr_idx, input logic [31:0] wr_data,
                          output int lat, output logic [31:0] d, output logic [1:0] r,
                          output bit stable, output bit busy_ok,
                          output logic post_rvalid, output logic post_arready,
                          output logic post_busy);
      int guard;
      stable = 1'b1; busy_ok = 1'b1; lat = 0; guard = 0;
      arvalid = 1'b1; araddr = a;
      while (!arready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (wr_at == 0) begin
         reg_we = 1'b1; reg_waddr = 3'(wr_idx); reg_wdata = wr_data;
      end
      @(posedge clk); #1;
      reg_we = 1'b0; arvalid = 1'b0; araddr = $urandom;
      if (busy !== 1'b1) busy_ok = 1'b0;
      while (rvalid !== 1'b1 && lat < 40) begin
         if (wr_at == lat + 1) begin
            reg_we = 1'b1; reg_waddr = 3'(wr_idx); reg_wdata = wr_data;
         end
         @(posedge clk); #1;
         reg_we = 1'b0; lat++;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      d = rdata; r = rresp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (rvalid !== 1'b1 || rdata !== d || rresp !== r) stable = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      post_rvalid = rvalid; post_arready = arready; post_busy = busy;
      if (wr_at >= 0) mregs[wr_idx] = wr_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({arready, rvalid, busy, rresp, rdata} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got arready=%b rvalid=%b busy=%b rresp=%b rdata=%h, expected all zero",
                  arready, rvalid, busy, rresp, rdata);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (arready !== 1'b0) begin
         n_fail++; $display("FAIL reset_release_arready: got %b expected 0", arready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (arready !== 1'b1) begin
         n_fail++; $display("FAIL first_clock_arready: got %b expected 1", arready);
      end
   endtask

   task automatic test_basic_read();
      int lat; logic [31:0] d; logic [1:0] r; bit st, bo; logic pv, pa, pb;
      reg_write(3, 32'hDEAD_BEEF);
      do_read(32'h4000_000C, 0, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if (lat !== RD_LATENCY) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, RD_LATENCY); end
      n_checks++;
      if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_rdata: got %h expected deadbeef", d); end
      n_checks++;
      if (r !== 2'b00) begin n_fail++; $display("FAIL basic_rresp: got %b expected 00", r); end
      n_checks++;
      if (bo !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got low during transaction, expected high"); end
      n_checks++;
      if ({pv, pa, pb} !== 3'b010) begin
         n_fail++; $display("FAIL basic_after_r: got rvalid=%b arready=%b busy=%b expected 0 1 0", pv, pa, pb);
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] d, ed; logic [1:0] r, er; bit st, bo; logic pv, pa, pb;
      reg_write(5, 32'h1234_5678);
      model_read(32'h4000_0014, ed, er);
      do_read(32'h4000_0014, 5, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if ({d, r} !== {ed, er}) begin n_fail++; $display("FAIL bp_data: got %h/%b expected %h/%b", d, r, ed, er); end
      n_checks++;
      if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got unstable R channel expected stable"); end
      n_checks++;
      if (pv !== 1'b0) begin n_fail++; $display("FAIL bp_single_beat: got rvalid=%b expected 0", pv); end
      n_checks++;
      if (pa !== 1'b1) begin n_fail++; $display("FAIL bp_arready_after: got %b expected 1", pa); end
   endtask

   task automatic test_decode();
      int lat; logic [31:0] d, ed; logic [1:0] r, er; bit st, bo; logic pv, pa, pb;
      reg_write(1, 32'hCAFE_0001);
      do_read(32'h4000_0020, 1, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if ({d, r} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL miss: got %h/%b expected 00000000/10", d, r); end
      n_checks++;
      if (lat !== RD_LATENCY) begin n_fail++; $display("FAIL miss_latency: got %0d expected %0d", lat, RD_LATENCY); end
      model_read(32'h4000_0005, ed, er);
      do_read(32'h4000_0005, 0, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if ({d, r} !== {ed, er}) begin n_fail++; $display("FAIL unaligned: got %h/%b expected %h/%b", d, r, ed, er); end
      do_read(32'h3FFF_FFFC, 0, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if ({d, r} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL below_base: got %h/%b expected 00000000/10", d, r); end
   endtask

   task automatic test_write_race();
      int lat; logic [31:0] d; logic [1:0] r; bit st, bo; logic pv, pa, pb;
      reg_write(2, 32'd1);
      do_read(32'h4000_0008, 0, RD_LATENCY, 2, 32'd2, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL race_old_value: got %h expected 00000001", d); end
      do_read(32'h4000_0008, 0, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if (d !== 32'd2) begin n_fail++; $display("FAIL race_new_value: got %h expected 00000002", d); end
   endtask

   task automatic test_reset_mid_read();
      int lat, guard; logic [31:0] d; logic [1:0] r; bit st, bo, seen; logic pv, pa, pb;
      reg_write(0, 32'hA5A5_A5A5);
      arvalid = 1'b1; araddr = BASE; guard = 0;
      while (!arready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({arready, rvalid, busy} !== 3'b000) begin
         n_fail++; $display("FAIL midreset_async: got arready=%b rvalid=%b busy=%b expected 0 0 0", arready, rvalid, busy);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 32'h0;
      seen = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (arready !== 1'b1) begin n_fail++; $display("FAIL midreset_arready: got %b expected 1", arready); end
      for (int i = 0; i < 10; i++) begin
         if (rvalid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_beat: got rvalid high expected none"); end
      do_read(BASE, 0, -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
      n_checks++;
      if ({d, r} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL midreset_reg0: got %h/%b expected 00000000/00", d, r); end
      n_checks++;
      if (lat !== RD_LATENCY) begin n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", lat, RD_LATENCY); end
   endtask

   task automatic test_random();
      int lat; logic [31:0] a, d, ed; logic [1:0] r, er; bit st, bo; logic pv, pa, pb;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) reg_write($urandom_range(0, NUM_REGS - 1), $urandom);
         case ($urandom_range(0, 3))
            0: a = BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1));
            1: a = BASE + 32'($urandom_range(0, 31));
            2: a = BASE + 32'($urandom_range(24, 80));
            default: a = $urandom;
         endcase
         model_read(a, ed, er);
         do_read(a, $urandom_range(0, 3), -1, 0, 32'h0, lat, d, r, st, bo, pv, pa, pb);
         n_checks++;
         if ({d, r} !== {ed, er}) begin
            n_fail++; $display("FAIL rand_read addr=%h: got %h/%b expected %h/%b", a, d, r, ed, er);
         end
         n_checks++;
         if (lat !== RD_LATENCY) begin n_fail++; $display("FAIL rand_latency addr=%h: got %0d expected %0d", a, lat, RD_LATENCY); end
         n_checks++;
         if (st !== 1'b1 || pv !== 1'b0) begin
            n_fail++; $display("FAIL rand_hold addr=%h: got stable=%b post_rvalid=%b expected 1 0", a, st, pv);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; arvalid = 1'b0; araddr = 32'h0; rready = 1'b0;
      reg_we = 1'b0; reg_waddr = 3'd0; reg_wdata = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 32'h0;
      test_reset();
      test_basic_read();
      test_backpressure();
      test_decode();
      test_write_race();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
